// File: rtl/map_tile_arbiter.sv
// rtl/map_tile_arbiter.sv - single-port tile-map RAM arbiter with pellet tracking
module map_tile_arbiter #(
  parameter int MAP_W       = 21,
  parameter int MAP_H       = 25,
  parameter int PELLET_INIT = 200,
  parameter int STARVE_MAX  = 4
) (
  input  logic       clock,
  input  logic       resetn,
  // game / collision requester
  input  logic       game_req,
  input  logic       game_we,
  input  logic [4:0] game_x,
  input  logic [4:0] game_y,
  input  logic [2:0] game_wdata,
  output logic       game_ack,
  output logic [2:0] game_rdata,
  output logic       power_eaten,
  // VGA renderer requester (read-only)
  input  logic       vga_req,
  input  logic [4:0] vga_x,
  input  logic [4:0] vga_y,
  output logic       vga_ack,
  output logic [2:0] vga_rdata,
  // tile-map RAM
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [2:0] ram_wdata,
  input  logic [2:0] ram_rdata,
  // level bookkeeping
  input  logic       level_reload,
  output logic [7:0] pellets_left,
  output logic       level_clear
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  localparam logic [2:0] TILE_POWER  = 3'b001;
  localparam logic [2:0] TILE_PELLET = 3'b010;
  localparam logic [2:0] TILE_WALL   = 3'b011;

  localparam int         SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [7:0] PELLET_RST = 8'(PELLET_INIT);
  localparam logic [4:0] MAP_W_L    = 5'(MAP_W);
  localparam logic [4:0] MAP_H_L    = 5'(MAP_H);

  logic [1:0]    state;
  logic          cur_game;   // in-flight request belongs to the game path
  logic          cur_we;     // in-flight request is a read-modify-write
  logic          cur_oor;    // in-flight coordinates are off the map
  logic [2:0]    cur_wdata;
  logic [SW-1:0] starve_cnt;

  logic game_elig, vga_elig, ack_busy;
  logic grant_game, grant_vga;
  logic game_oor, vga_oor;
  logic dec_en;
  logic [7:0] pellets_nxt;

  function automatic logic is_pellet(input logic [2:0] t);
    return (t == TILE_POWER) || (t == TILE_PELLET);
  endfunction

  // Arbitration: VGA normally wins; a starved game request wins once the
  // limit is hit. No grant is issued while an ack is on the bus, so a
  // requester still holding its req in its ack cycle is never re-served and
  // the other side does not slip in ahead of the normal priority.
  always_comb begin
    game_oor   = (game_x >= MAP_W_L) || (game_y >= MAP_H_L);
    vga_oor    = (vga_x  >= MAP_W_L) || (vga_y  >= MAP_H_L);
    game_elig  = game_req && !game_ack;
    vga_elig   = vga_req  && !vga_ack;
    ack_busy   = game_ack || vga_ack;
    grant_game = (state == ST_IDLE) && !ack_busy && game_elig &&
                 (!vga_elig || (starve_cnt == STARVE_LIM));
    grant_vga  = (state == ST_IDLE) && !ack_busy && vga_elig && !grant_game;
  end

  // Pellet count next value: eating a pellet (old pellet tile replaced by a
  // non-pellet) decrements with saturation; a reload overrides everything.
  always_comb begin
    dec_en = (state == ST_WR) && cur_game && !cur_oor &&
             is_pellet(game_rdata) && !is_pellet(cur_wdata);
    pellets_nxt = pellets_left;
    if (level_reload) begin
      pellets_nxt = PELLET_RST;
    end else if (dec_en && (pellets_left != 8'd0)) begin
      pellets_nxt = pellets_left - 8'd1;
    end
  end

  // Request FSM and RAM-side registers: grant, wait a cycle for the RAM,
  // capture the tile, and optionally write the new tile back.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      cur_game    <= 1'b0;
      cur_we      <= 1'b0;
      cur_oor     <= 1'b0;
      cur_wdata   <= 3'b000;
      ram_addr    <= 10'd0;
      ram_we      <= 1'b0;
      ram_wdata   <= 3'b000;
      game_ack    <= 1'b0;
      game_rdata  <= 3'b000;
      power_eaten <= 1'b0;
      vga_ack     <= 1'b0;
      vga_rdata   <= 3'b000;
    end else begin
      game_ack    <= 1'b0;
      vga_ack     <= 1'b0;
      power_eaten <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_game) begin
            cur_game  <= 1'b1;
            cur_we    <= game_we;
            cur_oor   <= game_oor;
            cur_wdata <= game_wdata;
            if (!game_oor) ram_addr <= {game_y, game_x};
            ram_we    <= 1'b0;
            state     <= ST_RD;
          end else if (grant_vga) begin
            cur_game  <= 1'b0;
            cur_we    <= 1'b0;
            cur_oor   <= vga_oor;
            if (!vga_oor) ram_addr <= {vga_y, vga_x};
            ram_we    <= 1'b0;
            state     <= ST_RD;
          end
        end
        ST_RD: begin
          state <= ST_CAP;
        end
        ST_CAP: begin
          if (cur_game) begin
            game_rdata <= cur_oor ? TILE_WALL : ram_rdata;
            if (cur_we) begin
              // off-map writes still take the WR cycle so latency matches
              ram_we    <= !cur_oor;
              ram_wdata <= cur_wdata;
              state     <= ST_WR;
            end else begin
              game_ack <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            vga_rdata <= cur_oor ? TILE_WALL : ram_rdata;
            vga_ack   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WR: begin
          ram_we      <= 1'b0;
          game_ack    <= 1'b1;
          power_eaten <= !cur_oor && (game_rdata == TILE_POWER);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Starvation counter: counts VGA wins while the game waits, cleared when
  // the game is finally served.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (grant_game) begin
      starve_cnt <= '0;
    end else if (grant_vga && game_req && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Pellet count and level-clear flag, flag aligned with the count it reflects.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pellets_left <= PELLET_RST;
      level_clear  <= 1'b0;
    end else begin
      pellets_left <= pellets_nxt;
      level_clear  <= (pellets_nxt == 8'd0);
    end
  end

endmodule

// File: tb/tb_map_tile_arbiter.sv
// tb/tb_map_tile_arbiter.sv - self-checking bench for map_tile_arbiter
module tb_map_tile_arbiter;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  logic       game_req = 1'b0, game_we = 1'b0;
  logic [4:0] game_x = '0, game_y = '0;
  logic [2:0] game_wdata = '0;
  logic       vga_req = 1'b0;
  logic [4:0] vga_x = '0, vga_y = '0;
  logic       level_reload = 1'b0;
  logic       preload = 1'b1;

  logic       g_ack0, pw0, v_ack0, we0, clr0;
  logic [2:0] g_rd0, v_rd0, wd0, rr0;
  logic [9:0] a0;
  logic [7:0] pl0;
  logic       g_ack1, pw1, v_ack1, we1, clr1;
  logic [2:0] g_rd1, v_rd1, wd1, rr1;
  logic [9:0] a1;
  logic [7:0] pl1;

  map_tile_arbiter u_dut0 (
    .clock(clock), .resetn(resetn),
    .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
    .game_wdata(game_wdata), .game_ack(g_ack0), .game_rdata(g_rd0), .power_eaten(pw0),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y), .vga_ack(v_ack0), .vga_rdata(v_rd0),
    .ram_addr(a0), .ram_we(we0), .ram_wdata(wd0), .ram_rdata(rr0),
    .level_reload(level_reload), .pellets_left(pl0), .level_clear(clr0)
  );

  map_tile_arbiter #(.PELLET_INIT(1)) u_dut1 (
    .clock(clock), .resetn(resetn),
    .game_req(game_req), .game_we(game_we), .game_x(game_x), .game_y(game_y),
    .game_wdata(game_wdata), .game_ack(g_ack1), .game_rdata(g_rd1), .power_eaten(pw1),
    .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y), .vga_ack(v_ack1), .vga_rdata(v_rd1),
    .ram_addr(a1), .ram_we(we1), .ram_wdata(wd1), .ram_rdata(rr1),
    .level_reload(level_reload), .pellets_left(pl1), .level_clear(clr1)
  );

  // initial map contents, index = {y,x}
  function automatic logic [2:0] tile_init(input int idx);
    case (idx)
      131, 263, 788, 461, 800, 121, 22: return 3'b010;
      197, 33:                          return 3'b011;
      329, 395, 1023:                   return 3'b001;
      default:                          return 3'b000;
    endcase
  endfunction

  logic [2:0] mem0 [0:1023];
  logic [2:0] mem1 [0:1023];

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= tile_init(i);
        mem1[i] <= tile_init(i);
      end
    end else begin
      if (we0) mem0[a0] <= wd0;
      if (we1) mem1[a1] <= wd1;
      rr0 <= mem0[a0];
      rr1 <= mem1[a1];
    end
  end

  int         we_cnt0 = 0;
  logic [9:0] we_addr0 = '0;
  logic [2:0] we_data0 = '0;
  always @(negedge clock) begin
    if (we0) begin
      we_cnt0++;
      we_addr0 = a0;
      we_data0 = wd0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         we;
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] wd;
    logic [2:0] ex_rd;
    bit         ex_pw;
    logic [7:0] ex_pl;
    int         ex_lat;
    int         ex_we;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];
  logic [7:0] last_pl1;
  logic       last_clr1;

  task automatic game_txn(input vec_t v, input string tag);
    vec_t e;
    int   lat;
    int   base;
    bit   got;
    exp_q.push_back(v);
    base = we_cnt0;
    @(negedge clock);
    game_req = 1'b1; game_we = v.we; game_x = v.x; game_y = v.y; game_wdata = v.wd;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (g_ack0) got = 1'b1;
    end
    chk({tag, " ack"}, got, 1);
    e = exp_q.pop_front();
    if (got) begin
      chk({tag, " latency"}, lat, e.ex_lat);
      chk({tag, " rdata"}, g_rd0, e.ex_rd);
      chk({tag, " power_eaten"}, pw0, e.ex_pw);
      chk({tag, " pellets"}, pl0, e.ex_pl);
      chk({tag, " ack dut1"}, g_ack1, 1);
      chk({tag, " power dut1"}, pw1, e.ex_pw);
      last_pl1  = pl1;
      last_clr1 = clr1;
    end
    chk({tag, " ram_we pulses"}, we_cnt0 - base, e.ex_we);
    if (e.ex_we == 1) begin
      chk({tag, " we addr"}, we_addr0, {e.y, e.x});
      chk({tag, " we data"}, we_data0, e.wd);
    end
    game_req = 1'b0;
  endtask

  task automatic vga_txn(input logic [4:0] x, input logic [4:0] y,
                         input logic [2:0] exr, input string tag);
    int lat;
    bit got;
    @(negedge clock);
    vga_req = 1'b1; vga_x = x; vga_y = y;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      lat++;
      if (v_ack0) got = 1'b1;
    end
    chk({tag, " ack"}, got, 1);
    if (got) begin
      chk({tag, " latency"}, lat, 3);
      chk({tag, " rdata"}, v_rd0, exr);
    end
    vga_req = 1'b0;
  endtask

  initial begin
    int vcnt;
    bit got;
    vecs[0]  = '{0,  3,  4, 3'b000, 3'b010, 0, 200, 3, 0};
    vecs[1]  = '{1,  3,  4, 3'b000, 3'b010, 0, 199, 4, 1};
    vecs[2]  = '{0,  3,  4, 3'b000, 3'b000, 0, 199, 3, 0};
    vecs[3]  = '{1,  5,  6, 3'b000, 3'b011, 0, 199, 4, 1};
    vecs[4]  = '{1,  7,  8, 3'b010, 3'b010, 0, 199, 4, 1};
    vecs[5]  = '{1,  9, 10, 3'b011, 3'b001, 1, 198, 4, 1};
    vecs[6]  = '{0, 25,  0, 3'b000, 3'b011, 0, 198, 3, 0};
    vecs[7]  = '{1, 25,  3, 3'b000, 3'b011, 0, 198, 4, 0};
    vecs[8]  = '{1,  0, 25, 3'b000, 3'b011, 0, 198, 4, 0};
    vecs[9]  = '{1, 20, 24, 3'b000, 3'b010, 0, 197, 4, 1};
    vecs[10] = '{1,  2,  2, 3'b001, 3'b000, 0, 197, 4, 1};
    vecs[11] = '{0, 31, 31, 3'b000, 3'b011, 0, 197, 3, 0};

    // reset state
    repeat (3) @(negedge clock);
    preload = 1'b0;
    chk("reset outputs", {g_ack0, g_rd0, pw0, v_ack0, v_rd0, a0, we0, wd0, clr0}, 32'd0);
    chk("reset pellets", pl0, 200);
    chk("reset pellets dut1", pl1, 1);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // plain VGA reads, in range and off map
    vga_txn(5'd1, 5'd1, 3'b011, "vga read");
    vga_txn(5'd22, 5'd0, 3'b011, "vga oor");

    // table of game transactions
    for (int i = 0; i < 12; i++) begin
      game_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // simultaneous requests: VGA served STARVE_MAX times, then game
    @(negedge clock);
    vga_x = 5'd1; vga_y = 5'd1; vga_req = 1'b1;
    game_x = 5'd3; game_y = 5'd4; game_we = 1'b0; game_req = 1'b1;
    vcnt = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (v_ack0) vcnt++;
      if (g_ack0) got = 1'b1;
    end
    chk("starve game ack", got, 1);
    chk("starve vga grants", vcnt, 4);
    chk("starve game rdata", g_rd0, 3'b000);
    chk("starve cnt cleared", u_dut0.starve_cnt, 0);
    vga_req = 1'b0; game_req = 1'b0;
    @(negedge clock);

    // level clear on the PELLET_INIT=1 instance
    chk("dut1 empty", pl1, 0);
    chk("dut1 clear", clr1, 1);
    level_reload = 1'b1;
    @(negedge clock);
    level_reload = 1'b0;
    chk("reload pellets dut1", pl1, 1);
    chk("reload clear dut1", clr1, 0);
    chk("reload pellets dut0", pl0, 200);
    game_txn('{1, 11, 12, 3'b000, 3'b001, 1, 199, 4, 1}, "eat power");
    chk("eat pellets dut1", last_pl1, 0);
    chk("eat clear dut1", last_clr1, 1);
    @(negedge clock);
    level_reload = 1'b1;
    @(negedge clock);
    level_reload = 1'b0;
    chk("reload2 clear dut1", clr1, 0);

    // reset in the middle of a write-back
    @(negedge clock);
    game_req = 1'b1; game_we = 1'b1; game_x = 5'd13; game_y = 5'd14; game_wdata = 3'b000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (we0) got = 1'b1;
    end
    chk("reach WR", got, 1);
    resetn = 1'b0;
    #1;
    chk("abort ram_we", {we0, we1}, 0);
    chk("abort outputs", {g_ack0, g_rd0, pw0, v_ack0, v_rd0, a0, wd0, clr0}, 0);
    chk("abort state", u_dut0.state, 0);
    chk("abort pellets", pl0, 200);
    game_req = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort tile kept", mem0[461], 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
